// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Sequences a UART receiver. While disabled the receiver is held in reset.
//   While running, every completed byte is queued in a small FIFO with a
//   valid/ready output. A framing error is counted, the receiver is pulsed
//   into reset, and it is only re-armed after the serial line has been seen
//   idle (high) for IDLE_CLKS consecutive synchronized clocks.
//
// Ports
//   clk          system clock, rising edge
//   arst         asynchronous active-high reset
//   enable       1 = receive, 0 = hold receiver in reset
//   rx_line      raw serial line (asynchronous), watched for idle
//   rx_data      receiver parallel byte, valid with rx_done
//   rx_done      receiver one-cycle byte-complete pulse
//   rx_error     receiver sticky framing-error level
//   rx_rst_n     active-low reset to the receiver
//   m_data       FIFO head byte
//   m_valid      FIFO non-empty
//   m_ready      consumer accepts m_data when m_valid=1
//   overrun      sticky: a byte was dropped on a full FIFO
//   err_count    framing errors seen, saturating at 255
//   busy_recover high during error recovery
//   clr          clears overrun and err_count
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int IDLE_CLKS  = 5208,
   parameter int RST_CLKS   = 4
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       enable,
   input  logic       rx_line,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       rx_error,
   output logic       rx_rst_n,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       overrun,
   output logic [7:0] err_count,
   output logic       busy_recover,
   input  logic       clr
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int IW = $clog2(IDLE_CLKS + 1);
   localparam int RW = $clog2(RST_CLKS + 1);

   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLKS - 1);
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CLKS - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_DISABLED  = 2'd0,
      ST_RUN       = 2'd1,
      ST_RESET_RX  = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [IW-1:0]   idle_cnt_r;
   logic [IW-1:0]   idle_nxt_s;
   logic [RW-1:0]   rst_cnt_r;
   logic [RW-1:0]   rst_nxt_s;
   logic            err_hit_s;
   logic            line_meta_r;
   logic            line_sync_r;
   logic            rx_rst_n_r;
   logic            busy_r;

   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   cnt_r;
   logic            full_s;
   logic            pop_s;
   logic            push_s;
   logic            drop_s;
   logic            overrun_r;
   logic [7:0]      err_cnt_r;

   // Next-state and recovery counter logic
   always_comb begin
      state_nxt_s = state_r;
      idle_nxt_s  = idle_cnt_r;
      rst_nxt_s   = rst_cnt_r;
      err_hit_s   = 1'b0;
      if (!enable) begin
         state_nxt_s = ST_DISABLED;
         idle_nxt_s  = {IW{1'b0}};
         rst_nxt_s   = {RW{1'b0}};
      end else begin
         case (state_r)
            ST_DISABLED: begin
               state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
               if (rx_error) begin
                  state_nxt_s = ST_RESET_RX;
                  err_hit_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_RESET_RX: begin
               if (rst_cnt_r == RST_LAST) begin
                  state_nxt_s = ST_WAIT_IDLE;
                  rst_nxt_s   = {RW{1'b0}};
               end else begin
                  rst_nxt_s   = rst_cnt_r + RW'(1'b1);
               end
            end
            ST_WAIT_IDLE: begin
               if (!line_sync_r) begin
                  idle_nxt_s  = {IW{1'b0}};
               end else if (idle_cnt_r == IDLE_LAST) begin
                  // This sample completes IDLE_CLKS consecutive high clocks
                  idle_nxt_s  = {IW{1'b0}};
                  state_nxt_s = ST_RUN;
               end else begin
                  idle_nxt_s  = idle_cnt_r + IW'(1'b1);
               end
            end
            default: begin
               state_nxt_s = ST_DISABLED;
               idle_nxt_s  = {IW{1'b0}};
               rst_nxt_s   = {RW{1'b0}};
            end
         endcase
      end
   end

   // State, counters and registered receiver-control outputs
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_r    <= ST_DISABLED;
         idle_cnt_r <= {IW{1'b0}};
         rst_cnt_r  <= {RW{1'b0}};
         rx_rst_n_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         idle_cnt_r <= idle_nxt_s;
         rst_cnt_r  <= rst_nxt_s;
         rx_rst_n_r <= (state_nxt_s == ST_RUN);
         busy_r     <= (state_nxt_s == ST_RESET_RX) || (state_nxt_s == ST_WAIT_IDLE);
      end
   end

   // Line synchronizer; flushed while the receiver is being reset so idle
   // qualification only uses line samples taken after the reset pulse
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         line_meta_r <= 1'b1;
         line_sync_r <= 1'b1;
      end else if (state_r == ST_RESET_RX) begin
         line_meta_r <= 1'b0;
         line_sync_r <= 1'b0;
      end else begin
         line_meta_r <= rx_line;
         line_sync_r <= line_meta_r;
      end
   end

   // FIFO handshake decode; a same-cycle pop frees the slot for the push
   always_comb begin
      full_s = (cnt_r == DEPTH_C);
      pop_s  = (cnt_r != {CW{1'b0}}) && m_ready;
      push_s = (state_r == ST_RUN) && rx_done && (!full_s || pop_s);
      drop_s = (state_r == ST_RUN) && rx_done && full_s && !pop_s;
   end

   // FIFO storage
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 8'h00;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= rx_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1'b1);
            2'b01:   cnt_r <= cnt_r - CW'(1'b1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Sticky overrun flag and saturating error counter; clr wins
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         overrun_r <= 1'b0;
         err_cnt_r <= 8'h00;
      end else if (clr) begin
         overrun_r <= 1'b0;
         err_cnt_r <= 8'h00;
      end else begin
         if (drop_s) begin
            overrun_r <= 1'b1;
         end
         if (err_hit_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign rx_rst_n     = rx_rst_n_r;
   assign busy_recover = busy_r;
   assign m_valid      = (cnt_r != {CW{1'b0}});
   assign m_data       = mem_r[rd_ptr_r];
   assign overrun      = overrun_r;
   assign err_count    = err_cnt_r;

endmodule
